muldiv_sequencer: RTL

- Iterative multi-cycle multiply/divide unit for the RV32M extension, placed beside the single-cycle ALU in the execute stage.
- Accepts one operation per start pulse and computes it bit-serially over XLEN cycles.
- Holds busy high so the hazard unit stalls the fetch, decode and execute stages.
- Returns the result with a one-cycle done pulse, then releases the pipeline.

---
 rtl/muldiv_sequencer_if.sv | 13 +
 rtl/muldiv_sequencer.sv | 79 +++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle between the execute stage and the mul/div unit
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic start;
  logic flush;
  logic [2:0] funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic busy;
  logic done;
  logic [XLEN-1:0] result;
  modport master (output start, flush, funct3, src_a, src_b, input busy, done, result);
  modport slave (input start, flush, funct3, src_a, src_b, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial RV32M multiply/divide, one radix-2 step per cycle
module muldiv_sequencer #(parameter int XLEN = 32) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic neg, neg_a;
  logic [XLEN-1:0] m, res, a_mag, b_mag, q, r, fin;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [CW-1:0] cnt;
  logic sa, sb, a_neg, b_neg, done_w;
  logic [XLEN:0] s, r_sh;
  logic [XLEN+1:0] d;
  always_comb begin
    sa = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    sb = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg = sa & bus.src_a[XLEN-1];
    b_neg = sb & bus.src_b[XLEN-1];
    a_mag = a_neg ? -bus.src_a : bus.src_a;
    b_mag = b_neg ? -bus.src_b : bus.src_b;
    // multiply: acc = {partial sum, remaining multiplier}; divide: acc = {remainder, dividend/quotient}
    s = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
    r_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    d = {1'b0, r_sh} - {2'b0, m};
    acc_nx = op[2] ? {d[XLEN+1] ? r_sh[XLEN-1:0] : d[XLEN-1:0], acc[XLEN-2:0], ~d[XLEN+1]}
                   : {s, acc[XLEN-1:1]};
    prod = neg ? -acc : acc;
    q = acc[XLEN-1:0];
    r = acc[2*XLEN-1:XLEN];
    // a zero divisor leaves an all-ones quotient that must not be negated
    fin = !op[2] ? (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
        : op[1] ? (neg_a ? -r : r)
        : ((neg && m != '0) ? -q : q);
    done_w = (state == DONE) && !bus.flush;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      neg <= 1'b0;
      neg_a <= 1'b0;
      m <= '0;
      acc <= '0;
      cnt <= '0;
      res <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op <= bus.funct3;
          neg <= a_neg ^ b_neg;
          neg_a <= a_neg;
          m <= bus.funct3[2] ? b_mag : a_mag;
          acc <= {{XLEN{1'b0}}, bus.funct3[2] ? a_mag : b_mag};
          cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) state <= DONE;
        end
        DONE: begin
          res <= fin;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = done_w;
  assign bus.result = done_w ? fin : res;
endmodule
